alu_cmd_issuer: RTL and testbench
=================================

// Module: alu_cmd_issuer
// PURPOSE
//  Initiator side of the combinational ALU interface (a, b, s -> F).
//  Accepts operation commands over a valid/ready handshake and reads operands from a small internal register file.
//  Drives registered operands/opcode to an external ALU, captures the result one cycle later, writes it back, and
//  returns it over a valid/ready response channel.
//  Sits between a command source (bench, sequencer, CPU stub) and the ALU.
// PARAMETERS
//  n     4  data width; must match the ALU parameter n
//  REGS  4  register-file depth, power of two
//  AW    2  register address width, = log2(REGS)
// PORTS
//  clk        in   1   single clock; all state updates on posedge clk
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   issuer can accept a command
//  cmd_ld     in   1   1: load immediate into rd, no ALU op; 0: ALU op
//  cmd_op     in   3   opcode, passed unchanged to alu_s
//  cmd_rd     in   AW  destination register
//  cmd_ra     in   AW  operand A register
//  cmd_rb     in   AW  operand B register
//  cmd_imm_en in   1   1: operand B = cmd_imm instead of rf[cmd_rb]
//  cmd_imm    in   n   immediate value
//  alu_a      out  n   to ALU a
//  alu_b      out  n   to ALU b
//  alu_s      out  3   to ALU s
//  alu_f      in   n   from ALU F (combinational from alu_a/b/s)
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  n   result value (ALU result or loaded immediate)
//  rsp_rd     out  AW  register written
// BEHAVIOUR
//  Reset (rst=1 at posedge), all state cleared:
//   - rf[*]=0, state=IDLE
//   - alu_a=alu_b=0, alu_s=0
//   - rsp_valid=0, rsp_data=0, rsp_rd=0
//   - cmd_ready=1 in the first cycle after reset
//   - rst mid-operation aborts: no write-back, no response, pending command lost
//  States:
//   - IDLE:    cmd_ready=1; outputs of all other states have cmd_ready=0.
//              Handshake = cmd_valid & cmd_ready at posedge.
//              ALU op accepted: latch alu_a=rf[ra]; alu_b = imm_en ? cmd_imm : rf[rb]; alu_s=cmd_op;
//                latch rd; -> ISSUE.
//              Load accepted: rf[rd]=cmd_imm, rsp_data=cmd_imm, rsp_rd=rd; -> RESP.
//   - ISSUE:   one settle cycle; alu_a/b/s held stable -> CAPTURE.
//   - CAPTURE: rf[rd]=alu_f, rsp_data=alu_f, rsp_rd=rd -> RESP.
//   - RESP:    rsp_valid=1; rsp_data/rsp_rd stable.
//              rsp_valid & rsp_ready at posedge -> IDLE; rsp_valid=0 next cycle.
//  Timing and held values:
//   - Latency, ALU op: command accepted at edge T -> rsp_valid high from edge T+3.
//   - Latency, load: rsp_valid high from edge T+1.
//   - alu_a/b/s hold their last issued value outside ISSUE/CAPTURE; not cleared between ops.
//  Operand and width rules:
//   - Operands are read at acceptance; ra, rb, rd may be equal, and the read sees the pre-write value.
//   - Only one command in flight; back-to-back commands therefore have no hazards.
//   - rsp_ready held high in RESP: one-cycle RESP; next command accepted one cycle later (IDLE).
//   - cmd_valid in non-IDLE states ignored; the command is not consumed.
//   - All values are n bits; no carry or flags. Overflow behaviour is the ALU's (F truncated to n).
//   - Register 0 is an ordinary writable register.
// TESTING  (bench ALU stub: F = s==3'b000 ? a+b : a-b, mod 2^n; n=4, REGS=4)
//  1. rst held 2 cycles, then released:
//     - all rf = 0, rsp_valid=0, alu_a/b/s=0
//     - cmd_ready=1 in the first cycle after release
//  2. ld r1=5, ld r2=2, op 000 rd=3 ra=1 rb=2:
//     - alu_a=5, alu_b=2, alu_s=000 during ISSUE
//     - rsp_data=7, rsp_rd=3 exactly 3 cycles after acceptance
//  3. op 001 rd=0 ra=1 imm_en=1 imm=9 (r1=5):
//     - alu_b=9
//     - rsp_data=4'hC (wrap), r0=12
//  4. rsp_ready low for 4 cycles in RESP:
//     - rsp_valid/rsp_data stable throughout
//     - cmd_valid pulses ignored, cmd_ready=0
//     - raising rsp_ready completes the handshake; cmd_ready=1 next cycle
//  5. op 000 rd=1 ra=1 rb=1 (r1=8):
//     - result 0 (8+8 mod 16), r1=0
//  6. rst asserted in CAPTURE (rd=2, r2=7):
//     - no response
//     - all registers 0 after reset (including r2=0)
//     - cmd_ready=1 next cycle

Source files
------------

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and response bundle for alu_cmd_issuer
//
// Purpose: groups the three channels of the issuer into one bundle.
//   command channel  : cmd_valid/cmd_ready plus ld, op, rd, ra, rb, imm_en, imm
//   ALU bus          : alu_a, alu_b, alu_s out to the ALU; alu_f back from it
//   response channel : rsp_valid/rsp_ready plus rsp_data, rsp_rd
// Modports:
//   master : command source / response consumer / ALU side
//   slave  : the issuer itself
interface alu_cmd_issuer_if #(
  parameter int n  = 4,
  parameter int AW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_ld;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic          cmd_imm_en;
  logic [n-1:0]  cmd_imm;

  logic [n-1:0]  alu_a;
  logic [n-1:0]  alu_b;
  logic [2:0]    alu_s;
  logic [n-1:0]  alu_f;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [n-1:0]  rsp_data;
  logic [AW-1:0] rsp_rd;

  modport master (
    output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    output alu_f,
    input  rsp_valid, rsp_data, rsp_rd,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    input  alu_f,
    output rsp_valid, rsp_data, rsp_rd,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues register-file operands to an external ALU and returns results
//
// Purpose: accepts one command at a time. A load writes cmd_imm straight into
//   the register file and responds next cycle. An ALU op latches operands from
//   the register file (or the immediate for B), holds them on the ALU bus for a
//   settle cycle, captures alu_f, writes it back and responds.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset; aborts any operation in flight
//   bus  : alu_cmd_issuer_if.slave - command in, ALU bus out, response out
// Parameters:
//   n    : data width (must match the ALU)
//   REGS : register-file depth, power of two
//   AW   : register address width, log2(REGS)
module alu_cmd_issuer #(
  parameter int n    = 4,
  parameter int REGS = 4,
  parameter int AW   = 2
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_issuer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  rf_q [REGS];
  logic [n-1:0]  rf_d [REGS];
  logic [n-1:0]  alu_a_q, alu_a_d;
  logic [n-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    alu_s_q, alu_s_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [n-1:0]  rsp_data_q, rsp_data_d;
  logic [AW-1:0] rsp_rd_q, rsp_rd_d;
  logic          cmd_ready;
  logic          rsp_valid;

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    rd_d       = rd_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_ld) begin
            rf_d[bus.cmd_rd] = bus.cmd_imm;
            rsp_data_d       = bus.cmd_imm;
            rsp_rd_d         = bus.cmd_rd;
            state_d          = RESP;
          end else begin
            // Operands come from rf_q, so a source equal to rd sees the
            // value from before this command's write-back.
            alu_a_d = rf_q[bus.cmd_ra];
            alu_b_d = bus.cmd_imm_en ? bus.cmd_imm : rf_q[bus.cmd_rb];
            alu_s_d = bus.cmd_op;
            rd_d    = bus.cmd_rd;
            state_d = ISSUE;
          end
        end
      end

      // Operands have just been registered; give the combinational ALU a
      // full cycle before sampling alu_f.
      ISSUE: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        rf_d[rd_q] = bus.alu_f;
        rsp_data_d = bus.alu_f;
        rsp_rd_d   = rd_q;
        state_d    = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rf_q       <= '{default: '0};
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;

  localparam int N  = 4;
  localparam int AW = 2;

  typedef struct {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       imm_en;
    logic [3:0] imm;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_data;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] rd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb [$];
  vec_t vecs [14];

  alu_cmd_issuer_if #(.n(N), .AW(AW)) bus ();

  alu_cmd_issuer #(.n(N), .REGS(4), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU stub: add for s==0, subtract otherwise, mod 2^n
  assign bus.alu_f = (bus.alu_s == 3'b000) ? bus.alu_a + bus.alu_b : bus.alu_a - bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] ra, input logic [1:0] rb, input logic imm_en,
                              input logic [3:0] imm, input logic [3:0] exp_a,
                              input logic [3:0] exp_b, input logic [3:0] exp_data);
    vec_t v;
    v.ld = ld; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm_en = imm_en;
    v.imm = imm; v.exp_a = exp_a; v.exp_b = exp_b; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to its response. hold > 0 keeps
  // rsp_ready low that many cycles in RESP while pulsing a stray load
  // (r0 = 15) that must be ignored.
  task automatic run_cmd(input string tag, input vec_t v, input int hold);
    int   w;
    int   lat;
    exp_t e;
    w = 0;
    while (!bus.cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      check({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_ld     = v.ld;
    bus.cmd_op     = v.op;
    bus.cmd_rd     = v.rd;
    bus.cmd_ra     = v.ra;
    bus.cmd_rb     = v.rb;
    bus.cmd_imm_en = v.imm_en;
    bus.cmd_imm    = v.imm;
    @(posedge clk);
    e.data = v.exp_data;
    e.rd   = v.rd;
    sb.push_back(e);

    lat = 0;
    do begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      lat++;
      if (lat == 1 && !v.ld) begin
        check({tag, "_alu_a"}, bus.alu_a, v.exp_a);
        check({tag, "_alu_b"}, bus.alu_b, v.exp_b);
        check({tag, "_alu_s"}, bus.alu_s, v.op);
        check({tag, "_busy_ready"}, bus.cmd_ready, 1'b0);
      end
    end while (!bus.rsp_valid && lat < 8);
    check({tag, "_latency"}, lat, v.ld ? 1 : 3);
    if (!bus.rsp_valid) return;

    if (hold > 0) begin
      bus.rsp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        check({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
        check({tag, "_hold_data"}, bus.rsp_data, v.exp_data);
        check({tag, "_hold_ready"}, bus.cmd_ready, 1'b0);
        bus.cmd_valid = (h % 2 == 0);
        bus.cmd_ld    = 1'b1;
        bus.cmd_rd    = 2'd0;
        bus.cmd_imm   = 4'hF;
        @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end

    if (sb.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rsp_data"}, bus.rsp_data, e.data);
      check({tag, "_rsp_rd"}, bus.rsp_rd, e.rd);
    end
    @(negedge clk);
    check({tag, "_valid_drop"}, bus.rsp_valid, 1'b0);
    check({tag, "_ready_back"}, bus.cmd_ready, 1'b1);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_ld     = 1'b0;
    bus.cmd_op     = 3'd0;
    bus.cmd_rd     = 2'd0;
    bus.cmd_ra     = 2'd0;
    bus.cmd_rb     = 2'd0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 4'd0;
    bus.rsp_ready  = 1'b1;

    //            ld op      rd ra rb ie imm  a     b     data
    vecs[0]  = mk(0, 3'b000, 0, 0, 0, 1, 0,   0,    0,    0);    // read r0
    vecs[1]  = mk(0, 3'b000, 1, 1, 0, 1, 0,   0,    0,    0);    // read r1
    vecs[2]  = mk(0, 3'b000, 2, 2, 0, 1, 0,   0,    0,    0);    // read r2
    vecs[3]  = mk(0, 3'b000, 3, 3, 0, 1, 0,   0,    0,    0);    // read r3
    vecs[4]  = mk(1, 3'b000, 1, 0, 0, 0, 5,   0,    0,    5);    // ld r1=5
    vecs[5]  = mk(1, 3'b000, 2, 0, 0, 0, 2,   0,    0,    2);    // ld r2=2
    vecs[6]  = mk(0, 3'b000, 3, 1, 2, 0, 0,   5,    2,    7);    // r3=r1+r2
    vecs[7]  = mk(0, 3'b001, 0, 1, 0, 1, 9,   5,    9,    4'hC); // r0=r1-9 wraps
    vecs[8]  = mk(0, 3'b000, 0, 0, 0, 1, 0,   4'hC, 0,    4'hC); // read r0
    vecs[9]  = mk(1, 3'b000, 1, 0, 0, 0, 8,   0,    0,    8);    // ld r1=8
    vecs[10] = mk(0, 3'b000, 1, 1, 1, 0, 0,   8,    8,    0);    // r1=r1+r1 wraps
    vecs[11] = mk(0, 3'b000, 1, 1, 0, 1, 0,   0,    0,    0);    // read r1
    vecs[12] = mk(0, 3'b000, 3, 3, 0, 1, 0,   7,    0,    7);    // read r3
    vecs[13] = mk(0, 3'b111, 2, 3, 0, 1, 3,   7,    3,    4);    // r2=r3-3

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 4'd0);
    check("rst_rsp_rd", bus.rsp_rd, 2'd0);
    check("rst_alu_a", bus.alu_a, 4'd0);
    check("rst_alu_b", bus.alu_b, 4'd0);
    check("rst_alu_s", bus.alu_s, 3'd0);

    for (int i = 0; i < 14; i++) begin
      run_cmd($sformatf("v%0d", i), vecs[i], 0);
    end

    // ALU bus keeps the last issued operands while idle
    check("held_alu_a", bus.alu_a, 4'd7);
    check("held_alu_b", bus.alu_b, 4'd3);
    check("held_alu_s", bus.alu_s, 3'b111);

    // Back-pressure in RESP with stray command pulses; r3 = 7 + 3
    run_cmd("bp", mk(0, 3'b000, 3, 3, 0, 1, 3, 7, 3, 4'hA), 4);
    run_cmd("bp_r0", mk(0, 3'b000, 0, 0, 0, 1, 0, 4'hC, 0, 4'hC), 0);
    run_cmd("bp_r3", mk(0, 3'b000, 3, 3, 0, 1, 0, 4'hA, 0, 4'hA), 0);
    run_cmd("bp_ld", mk(1, 3'b000, 1, 0, 0, 0, 4'h6, 0, 0, 4'h6), 2);

    // Reset while in CAPTURE aborts the write-back and the response
    run_cmd("ab_ld", mk(1, 3'b000, 2, 0, 0, 0, 7, 0, 0, 7), 0);
    bus.cmd_valid  = 1'b1;
    bus.cmd_ld     = 1'b0;
    bus.cmd_op     = 3'b000;
    bus.cmd_rd     = 2'd2;
    bus.cmd_ra     = 2'd2;
    bus.cmd_rb     = 2'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 4'd1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("ab_issue_a", bus.alu_a, 4'd7);
    @(posedge clk);
    @(negedge clk);
    check("ab_capture_valid", bus.rsp_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("ab_cmd_ready", bus.cmd_ready, 1'b1);
    check("ab_alu_a", bus.alu_a, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ab_no_rsp", bus.rsp_valid, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      run_cmd($sformatf("ab_r%0d", i), vecs[i], 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
